parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
Consumes the debounced entry and exit sensor levels produced by the Debouncer stage, one Debouncer instance per sensor. On each accepted event it tracks lot occupancy and drives a single barrier gate open for a fixed time. It sits directly downstream of the Debouncers and feeds the display/status logic of the smart parking system.

Parameters:
CAPACITY, 8, number of parking spots; legal range 1..(2^CNT_W - 1).
CNT_W, 4, width of the occupancy counter.
GATE_CYCLES, 20, clock cycles the gate is held open per event; must be >= 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
entrySensor  input  1  debounced entry-lane sensor level; 1 = car present.
exitSensor  input  1  debounced exit-lane sensor level; 1 = car present.
gateOpen  output  1  1 = barrier raised.
gateDir  output  1  direction of the current opening; 1 = entry, 0 = exit; valid only while gateOpen = 1, else 0.
occupancy  output  CNT_W  number of cars currently in the lot.
full  output  1  1 when occupancy == CAPACITY.
empty  output  1  1 when occupancy == 0.
reject  output  1  one-cycle pulse marking a refused event.

Behaviour:
- Reset values (cycle reset is sampled high):
  - gateOpen = 0, gateDir = 0, occupancy = 0, full = 0, empty = 1, reject = 0.
  - State = IDLE, timer = 0.
  - Edge-detect registers load the current sensor values, so a sensor held high through reset produces no event.
- Edge detection:
  - An event is a rising edge: sensor = 1 now and the registered previous value = 0.
  - Previous-value registers update every cycle, in every state.
- State machine states: IDLE, OPEN_IN, OPEN_OUT.
- IDLE, evaluated in this priority order:
  - Exit edge with occupancy > 0: go to OPEN_OUT; decrement occupancy; load timer = GATE_CYCLES - 1.
  - Exit edge with occupancy == 0: reject = 1 for one cycle; stay IDLE.
  - Entry edge, not full, and not accepted together with an exit: go to OPEN_IN; increment occupancy; load timer.
  - Entry edge while full: reject = 1; stay IDLE.
  - Simultaneous entry and exit edges: exit is served, entry is dropped silently (no reject pulse).
- OPEN_IN / OPEN_OUT:
  - gateOpen = 1; gateDir = 1 (OPEN_IN) or 0 (OPEN_OUT).
  - Timer decrements each cycle; when timer == 0, return to IDLE next cycle.
  - Gate is therefore high for exactly GATE_CYCLES cycles.
  - Edges arriving while not IDLE are dropped: no counter change, no reject.
- Latency: sensor rises before clock edge N → at edge N the state, occupancy and gateOpen all update together (1 cycle from sensor to outputs).
- Occupancy arithmetic:
  - Unsigned, saturating by construction: never exceeds CAPACITY, never wraps below 0.
  - full and empty are registered and updated in the same cycle as occupancy.
- reject: registered, high for exactly one cycle per refused event.
- Reset mid-opening: gate closes in the next cycle and occupancy clears to 0. There is no restore; the external system re-counts.

Optional Feature:
Macro REJECT_COUNT_EN.
- Defined:
  - Adds output port rejectCount, 8 bits.
  - Increments on every reject pulse and saturates at 255.
  - Reset value is 0.
- Undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then pulse entrySensor 0→1 → next edge: gateOpen = 1, gateDir = 1, occupancy = 1, empty = 0; gateOpen stays high exactly 20 cycles, then 0.
2. 8 entry events spaced 30 cycles apart, then a 9th → occupancy = 8, full = 1; the 9th gives reject = 1 for one cycle, gateOpen stays 0, occupancy stays 8.
3. From empty, exitSensor edge → reject one cycle, occupancy stays 0, no gate opening.
4. With occupancy = 3, entry and exit edges in the same cycle → OPEN_OUT (gateDir = 0), occupancy = 2, no reject.
5. Entry edge, then a new exit edge 5 cycles later while the gate is open → exit ignored; occupancy unchanged after the gate closes at cycle 20.
6. Hold entrySensor = 1 across reset release → no event. Mid-opening reset with occupancy = 5 → gateOpen = 0, occupancy = 0 next cycle. With REJECT_COUNT_EN, rejectCount increments once per reject from scenarios 2 and 3.

Source files
------------

// File: rtl/parking_gate_controller.sv
// -----------------------------------------------------------------------------
// parking_gate_controller
//
// Tracks lot occupancy from the debounced entry/exit sensor levels and drives a
// single barrier gate open for GATE_CYCLES cycles per accepted event. Refused
// events (exit from an empty lot, entry into a full lot) produce a one-cycle
// reject pulse. Events arriving while the gate is already open are dropped.
//
// Parameters:
//   CAPACITY    - number of parking spots, 1 .. 2**CNT_W-1
//   CNT_W       - width of the occupancy counter
//   GATE_CYCLES - cycles the gate stays raised per event, >= 1
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   entrySensor  in   debounced entry-lane level, 1 = car present
//   exitSensor   in   debounced exit-lane level, 1 = car present
//   gateOpen     out  1 = barrier raised
//   gateDir      out  1 = entry opening, 0 = exit opening (0 while closed)
//   occupancy    out  cars currently in the lot
//   full         out  occupancy == CAPACITY
//   empty        out  occupancy == 0
//   reject       out  one-cycle pulse per refused event
//   rejectCount  out  saturating count of reject pulses (REJECT_COUNT_EN only)
//
// Build option:
//   REJECT_COUNT_EN - when defined, adds the 8-bit rejectCount output.
// -----------------------------------------------------------------------------
module parking_gate_controller #(
  parameter int CAPACITY    = 8,
  parameter int CNT_W       = 4,
  parameter int GATE_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entrySensor,
  input  logic             exitSensor,
  output logic             gateOpen,
  output logic             gateDir,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             reject
`ifdef REJECT_COUNT_EN
  ,
  output logic [7:0]       rejectCount
`endif
);

  localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CAP_VAL    = CNT_W'(CAPACITY);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2
  } gateStateT;

  gateStateT          state, stateNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [CNT_W-1:0]   occNext;
  logic               rejectNext;
  logic               prevEntry, prevExit;
  logic               entryEdge, exitEdge;

  assign entryEdge = entrySensor & ~prevEntry;
  assign exitEdge  = exitSensor  & ~prevExit;

  // Gate outputs decode the registered state, so they change on the same edge
  // as occupancy.
  assign gateOpen = (state != IDLE);
  assign gateDir  = (state == OPEN_IN);

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    occNext    = occupancy;
    rejectNext = 1'b0;

    case (state)
      IDLE: begin
        // Exit has priority: a simultaneous entry edge is dropped silently.
        if (exitEdge) begin
          if (occupancy != '0) begin
            stateNext = OPEN_OUT;
            occNext   = occupancy - CNT_W'(1);
            timerNext = TIMER_LOAD;
          end else begin
            rejectNext = 1'b1;
          end
        end else if (entryEdge) begin
          if (occupancy != CAP_VAL) begin
            stateNext = OPEN_IN;
            occNext   = occupancy + CNT_W'(1);
            timerNext = TIMER_LOAD;
          end else begin
            rejectNext = 1'b1;
          end
        end
      end

      OPEN_IN, OPEN_OUT: begin
        // Loaded with GATE_CYCLES-1 so the gate stays up exactly GATE_CYCLES.
        if (timer == '0) begin
          stateNext = IDLE;
        end else begin
          timerNext = timer - TIMER_W'(1);
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // Edge-detect history tracks the sensors in every state, and loads the
    // live level during reset so a sensor held high produces no event.
    prevEntry <= entrySensor;
    prevExit  <= exitSensor;

    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      reject    <= 1'b0;
    end else begin
      state     <= stateNext;
      timer     <= timerNext;
      occupancy <= occNext;
      full      <= (occNext == CAP_VAL);
      empty     <= (occNext == '0);
      reject    <= rejectNext;
    end
  end

`ifdef REJECT_COUNT_EN
  // Counts alongside the reject register so the count and the pulse line up.
  always_ff @(posedge clk) begin
    if (reset) begin
      rejectCount <= '0;
    end else if (rejectNext && (rejectCount != 8'hFF)) begin
      rejectCount <= rejectCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_controller
//
// Directed bench for parking_gate_controller with default parameters
// (CAPACITY=8, CNT_W=4, GATE_CYCLES=20). A vector table covers reset, exit
// from an empty lot and the exact gate-open window; hand-written sequences
// cover filling the lot, simultaneous edges, events during an opening and
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_parking_gate_controller;

  logic       clk;
  logic       reset;
  logic       entrySensor;
  logic       exitSensor;
  logic       gateOpen;
  logic       gateDir;
  logic [3:0] occupancy;
  logic       full;
  logic       empty;
  logic       reject;
`ifdef REJECT_COUNT_EN
  logic [7:0] rejectCount;
`endif

  int testsRun  = 0;
  int testsFail = 0;

  parking_gate_controller #(
    .CAPACITY   (8),
    .CNT_W      (4),
    .GATE_CYCLES(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entrySensor(entrySensor),
    .exitSensor (exitSensor),
    .gateOpen   (gateOpen),
    .gateDir    (gateDir),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .reject     (reject)
`ifdef REJECT_COUNT_EN
    ,
    .rejectCount(rejectCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector: drive inputs, wait `cycles` rising edges, then compare outputs.
  typedef struct {
    string      name;
    logic       entry;
    logic       exitS;
    int         cycles;
    logic       expOpen;
    logic       expDir;
    logic [3:0] expOcc;
    logic       expFull;
    logic       expEmpty;
    logic       expReject;
  } vectorT;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic eOpen, input logic eDir,
                          input logic [3:0] eOcc, input logic eFull,
                          input logic eEmpty, input logic eRej);
    check({tag, ".gateOpen"},  32'(gateOpen),  32'(eOpen));
    check({tag, ".gateDir"},   32'(gateDir),   32'(eDir));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(eOcc));
    check({tag, ".full"},      32'(full),      32'(eFull));
    check({tag, ".empty"},     32'(empty),     32'(eEmpty));
    check({tag, ".reject"},    32'(reject),    32'(eRej));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vectorT vecs[$];

  // Watchdog: the run is a fixed number of cycles, so this only fires on a
  // broken bench or simulator.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun + 1, testsFail + 1);
    $fatal(1);
  end

  initial begin
    vectorT v;

    // Scenario 3 (exit from empty) then scenario 1 (one entry, 20-cycle gate).
    vecs.push_back('{"exit_empty",    1'b0, 1'b1, 1,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{"exit_held",     1'b0, 1'b1, 1,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"exit_release",  1'b0, 1'b0, 1,  1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"entry_edge",    1'b1, 1'b0, 1,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"entry_cyc19",   1'b1, 1'b0, 18, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"entry_cyc20",   1'b0, 1'b0, 1,  1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"entry_closed",  1'b0, 1'b0, 1,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0});

    reset       = 1'b1;
    entrySensor = 1'b0;
    exitSensor  = 1'b0;
    tick(3);
    checkAll("reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick(2);

    foreach (vecs[i]) begin
      v           = vecs[i];
      entrySensor = v.entry;
      exitSensor  = v.exitS;
      tick(v.cycles);
      checkAll(v.name, v.expOpen, v.expDir, v.expOcc, v.expFull, v.expEmpty, v.expReject);
    end

    // Scenario 2: fill the lot (occupancy 1 -> 8), then a refused 9th entry.
    for (int i = 2; i <= 8; i++) begin
      entrySensor = 1'b1;
      tick(1);
      checkAll($sformatf("fill_%0d", i), 1'b1, 1'b1, 4'(i), (i == 8), 1'b0, 1'b0);
      entrySensor = 1'b0;
      tick(29);
    end
    entrySensor = 1'b1;
    tick(1);
    checkAll("entry_full", 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkAll("entry_full_after", 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
    entrySensor = 1'b0;
    tick(1);

    // Drain to occupancy 3 with exit openings.
    for (int i = 7; i >= 3; i--) begin
      exitSensor = 1'b1;
      tick(1);
      checkAll($sformatf("drain_%0d", i), 1'b1, 1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
      exitSensor = 1'b0;
      tick(29);
    end

    // Scenario 4: simultaneous edges at occupancy 3 -> exit served, no reject.
    entrySensor = 1'b1;
    exitSensor  = 1'b1;
    tick(1);
    checkAll("simul", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    entrySensor = 1'b0;
    exitSensor  = 1'b0;
    tick(1);
    check("simul_no_reject", 32'(reject), 32'd0);
    tick(28);

    // Scenario 5: exit edge 5 cycles into an entry opening is ignored.
    entrySensor = 1'b1;
    tick(1);
    checkAll("busy_entry", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    entrySensor = 1'b0;
    tick(4);
    exitSensor = 1'b1;
    tick(1);
    checkAll("busy_exit", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    exitSensor = 1'b0;
    tick(14);
    check("busy_cyc20_open", 32'(gateOpen), 32'd1);
    tick(1);
    checkAll("busy_closed", 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    tick(10);

    // Scenario 6: reach occupancy 5 mid-opening, then reset with entry held.
    entrySensor = 1'b1;
    tick(1);
    entrySensor = 1'b0;
    tick(29);
    entrySensor = 1'b1;
    tick(1);
    checkAll("pre_reset", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    tick(3);
`ifdef REJECT_COUNT_EN
    // One refused exit (scenario 3) and one refused entry (scenario 2).
    check("rejectCount", 32'(rejectCount), 32'd2);
`endif
    reset = 1'b1;
    tick(1);
    checkAll("mid_reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(1);
    checkAll("held_through_reset", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("held_no_event", 32'(gateOpen), 32'd0);
`ifdef REJECT_COUNT_EN
    check("rejectCount_reset", 32'(rejectCount), 32'd0);
`endif
    entrySensor = 1'b0;
    tick(1);
    entrySensor = 1'b1;
    tick(1);
    checkAll("post_reset_entry", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
